// File: rtl/fp_convert_seq_if.sv
// Sample-in / result-out handshake bundle for the iterative fixed-to-float converter.
// master drives samples and accepts results; slave is the converter.
interface fp_convert_seq_if #(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int SIG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [EXP_W-1:0] out_exp;
    logic [SIG_W-1:0] out_sig;
    logic             out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_sig, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_sig, out_sat
    );
endinterface

// File: rtl/fp_convert_seq.sv
// Iterative fixed-to-float converter: normalises one bit per clock, rounds, saturates.
// FPCONV_RNE_EN selects round-to-nearest-even; default build rounds half-up.
module fp_convert_seq #(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int SIG_W = 4
) (
    input logic              clk,
    input logic              rst,
    fp_convert_seq_if.slave  bus
);
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [SIG_W-1:0] SIG_MSB = {1'b1, {(SIG_W-1){1'b0}}};
    localparam logic [IN_W-1:0]  IN_MIN  = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic [IN_W-1:0]  IN_MAX  = {1'b0, {(IN_W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t           state, state_nx;
    logic             sign_q;
    logic [IN_W-1:0]  mag_q;
    logic [EXP_W-1:0] e_q;
    logic             rbit_q;
    logic             sat_pre_q;
    logic             o_sign_q, o_sat_q;
    logic [EXP_W-1:0] o_exp_q;
    logic [SIG_W-1:0] o_sig_q;

    logic [IN_W-1:0]  abs_in;
    logic             big;
    logic [SIG_W-1:0] sig_lo;
    logic [SIG_W:0]   sig_inc;
    logic             round_up;
    logic             accept;

    // The most negative sample has no positive twin; clamp its magnitude.
    assign abs_in  = !bus.in_data[IN_W-1] ? bus.in_data :
                     (bus.in_data == IN_MIN) ? IN_MAX : -bus.in_data;
    assign big     = |mag_q[IN_W-1:SIG_W];
    assign sig_lo  = mag_q[SIG_W-1:0];
    assign sig_inc = {1'b0, sig_lo} + 1'b1;
    assign accept  = (state == IDLE) && bus.in_valid;

`ifdef FPCONV_RNE_EN
    logic sticky_q;
    assign round_up = rbit_q & (sticky_q | sig_lo[0]);

    always_ff @(posedge clk) begin
        if (rst || accept)
            sticky_q <= 1'b0;
        else if (state == NORM && big && e_q < EXP_MAX)
            sticky_q <= sticky_q | rbit_q;
    end
`else
    assign round_up = rbit_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        bus.in_ready = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nx = NORM;
            end
            NORM: begin
                if (!(big && e_q < EXP_MAX)) state_nx = ROUND;
            end
            ROUND: state_nx = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q    <= 1'b0;
            mag_q     <= '0;
            e_q       <= '0;
            rbit_q    <= 1'b0;
            sat_pre_q <= 1'b0;
            o_sign_q  <= 1'b0;
            o_exp_q   <= '0;
            o_sig_q   <= '0;
            o_sat_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    sign_q    <= bus.in_data[IN_W-1];
                    mag_q     <= abs_in;
                    e_q       <= '0;
                    rbit_q    <= 1'b0;
                    sat_pre_q <= 1'b0;
                end
                NORM: begin
                    if (big && e_q < EXP_MAX) begin
                        rbit_q <= mag_q[0];
                        mag_q  <= mag_q >> 1;
                        e_q    <= e_q + 1'b1;
                    end else if (big) begin
                        sat_pre_q <= 1'b1;
                    end
                end
                ROUND: begin
                    o_sign_q <= sign_q;
                    o_sat_q  <= 1'b0;
                    if (sat_pre_q || (round_up && sig_inc[SIG_W] && e_q == EXP_MAX)) begin
                        o_sig_q <= '1;
                        o_exp_q <= EXP_MAX;
                        o_sat_q <= 1'b1;
                    end else if (round_up && sig_inc[SIG_W]) begin
                        // Significand overflow renormalises to 1.000 at the next exponent.
                        o_sig_q <= SIG_MSB;
                        o_exp_q <= e_q + 1'b1;
                    end else if (round_up) begin
                        o_sig_q <= sig_inc[SIG_W-1:0];
                        o_exp_q <= e_q;
                    end else begin
                        o_sig_q <= sig_lo;
                        o_exp_q <= e_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_sign = o_sign_q;
    assign bus.out_exp  = o_exp_q;
    assign bus.out_sig  = o_sig_q;
    assign bus.out_sat  = o_sat_q;
endmodule

// File: doc/fp_convert_seq.md
Name: fp_convert_seq

Overview:
- Iterative, parametrised successor to the combinational rounding stage of the fixed-to-float converter.
- Accepts an IN_W-bit two's-complement sample and normalises it one bit per clock into sign / EXP_W exponent / SIG_W significand (value = sig * 2^exp).
- Rounds and saturates the result, then presents it on a valid/ready output.
- Sits between the sample register and the display/packing logic.

Parameters:
IN_W, 12, input width (two's complement), >= SIG_W+1
EXP_W, 3, exponent width; EXP_MAX = 2^EXP_W-1
SIG_W, 4, significand width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  converter can accept a sample
in_data  in  IN_W  two's-complement sample
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_sign  out  1  sign of sample
out_exp  out  EXP_W  exponent
out_sig  out  SIG_W  significand
out_sat  out  1  result clamped to largest magnitude

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state IDLE; in_ready=1, out_valid=0, out_sign=0, out_exp=0, out_sig=0, out_sat=0, internal regs 0. Reset mid-operation aborts the conversion and discards it; nothing is emitted.
- States: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, accept in_data and latch sign = MSB.
  - Latch magnitude M = |in_data|; the most negative input -2^(IN_W-1) maps to M = 2^(IN_W-1)-1.
  - Clear e, rbit and sticky, then go to NORM.
- NORM, one step per cycle:
  - If M >= 2^SIG_W and e < EXP_MAX: sticky <= sticky|rbit; rbit <= M[0]; M <= M>>1; e <= e+1.
  - Else if M >= 2^SIG_W (e == EXP_MAX): set sat_pre=1 and go to ROUND.
  - Else go to ROUND.
- ROUND, one cycle; registers the outputs:
  - sat_pre: sig = all ones, exp = EXP_MAX, out_sat=1.
  - Else if round-up (see Optional Feature):
    - sig+1 with carry out (sig was all ones) and e < EXP_MAX: sig = 2^(SIG_W-1), exp = e+1.
    - Carry out and e == EXP_MAX: sig = all ones, exp = EXP_MAX, out_sat=1.
    - No carry out: sig = sig+1, exp = e.
  - Else: sig = M[SIG_W-1:0], exp = e.
  - Go to DONE.
- DONE:
  - out_valid=1; outputs held stable while out_ready=0.
  - On out_ready, out_valid falls next cycle and state returns to IDLE.
- in_ready is 0 in NORM, ROUND and DONE; one conversion in flight.
- Latency from accept edge to out_valid = k+2 cycles, where k is the number of NORM shifts (0..EXP_MAX).
- Zero input: exp 0, sig 0, sign 0, latency 2.
- Outputs are only updated in ROUND. out_sign is passed through, including for zero magnitude results of negative inputs.

Optional Feature:
- Macro `FPCONV_RNE_EN`.
- Defined: round-to-nearest-even. Round up when rbit=1 and (sticky=1 or sig[0]=1).
- Undefined: round-half-up. Round up when rbit=1; sticky is ignored and may be optimised away.
- The saturation rules are identical in both builds.

Test Plan (defaults IN_W=12, EXP_W=3, SIG_W=4):
- Reset, then in_data=0 -> out_valid 2 cycles after accept; sign0 exp0 sig0 sat0; in_ready=0 until the handshake completes.
- in_data=422 -> exp5 sig13 sat0, out_valid 7 cycles after accept. in_data=-46 -> sign1 exp2 sig12.
- in_data=50 (tie) -> without macro exp2 sig13; with `FPCONV_RNE_EN` exp2 sig12.
- in_data=125 -> significand carry: exp4 sig8 sat0 (both builds).
- in_data=-2048 -> sign1 exp7 sig15 sat1. in_data=2047 -> sign0 exp7 sig15 sat1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles after out_valid: outputs stable, in_ready=0, and a second in_valid is not accepted.
  - Then assert out_ready: next sample is accepted only after return to IDLE.
  - Assert rst during NORM: next cycle out_valid=0, in_ready=1, and no stale result is ever emitted.
